tlb_op_seq: RTL and testbench

Multi-cycle sequencer for the TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) at the m1s stage. It accepts one operation at a time and holds the pipeline while the operation runs. It drives the TLB search, read and write ports in order, generates the one-cycle CP0 update strobes (Index on TLBP, EntryHi/EntryLo0/EntryLo1 on TLBR), and requests a refetch flush after any operation that changes translation state. It sits between the m1s stage control, the CP0 register block and the TLB array.

---
 rtl/tlb_op_seq.sv | 150 +++++++++++++++
 tb/tb_tlb_op_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_seq.sv
// Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR at m1s: one op at a time,
// IDLE -> SEARCH|READ|WRITE -> FINISH -> IDLE, with CP0 update and refetch strobes.
module tlb_op_seq #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m1s_valid,
    input  logic            m1s_ex,
    input  logic            m1s_inst_tlbp,
    input  logic            m1s_inst_tlbr,
    input  logic            m1s_inst_tlbwi,
    input  logic            m1s_inst_tlbwr,
    input  logic [31:0]     m1s_pc,
    input  logic            flush_in,
    input  logic [IDXW-1:0] cp0_index,
    input  logic [IDXW-1:0] cp0_random,
    input  logic            tlb_s_found,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic            op_stall,
    output logic            tlb_s_req,
    output logic            tlb_r_req,
    output logic [IDXW-1:0] tlb_r_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            cp0_tlbp_we,
    output logic            cp0_tlbp_found,
    output logic [IDXW-1:0] cp0_tlbp_index,
    output logic            cp0_tlbr_we,
    output logic            refetch_flush,
    output logic [31:0]     refetch_pc,
    output logic [2:0]      dbg_state
);

    // Handshake: m1s_valid qualifies the op bits; m1s holds the instruction
    // (valid, op bits, pc) stable for every cycle op_stall is high.

    if (TLBNUM != (1 << IDXW)) begin : g_bad_cfg
        $error("tlb_op_seq: TLBNUM must equal 2**IDXW");
    end

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEARCH = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_TLBP  = 3'd1;
    localparam logic [2:0] OP_TLBR  = 3'd2;
    localparam logic [2:0] OP_TLBWI = 3'd3;
    localparam logic [2:0] OP_TLBWR = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     pc_q, pc_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [2:0]      op_sel;
    logic [IDXW-1:0] idx_sel;
    logic            any_op;
    logic            start;
    logic            busy;
    logic            fin_live;

    assign any_op = m1s_inst_tlbp | m1s_inst_tlbr | m1s_inst_tlbwi | m1s_inst_tlbwr;
    assign start  = (state_q == ST_IDLE) & m1s_valid & ~m1s_ex & ~flush_in & any_op;

    always_comb begin
        op_sel = OP_NONE;
        if (m1s_inst_tlbp) begin
            op_sel = OP_TLBP;
        end else if (m1s_inst_tlbr) begin
            op_sel = OP_TLBR;
        end else if (m1s_inst_tlbwi) begin
            op_sel = OP_TLBWI;
        end else if (m1s_inst_tlbwr) begin
            op_sel = OP_TLBWR;
        end
    end

    // Random is sampled only here, so a later Random tick cannot move a TLBWR.
    assign idx_sel = (op_sel == OP_TLBWR) ? cp0_random : cp0_index;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op_sel;
                    pc_d  = m1s_pc;
                    idx_d = idx_sel;
                    case (op_sel)
                        OP_TLBP: state_d = ST_SEARCH;
                        OP_TLBR: state_d = ST_READ;
                        default: state_d = ST_WRITE;
                    endcase
                end
            end
            ST_SEARCH, ST_READ, ST_WRITE: state_d = ST_FINISH;
            ST_FINISH:                    state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
        if (flush_in && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            pc_q    <= 32'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q == ST_SEARCH) | (state_q == ST_READ) | (state_q == ST_WRITE);
    assign fin_live = (state_q == ST_FINISH) & ~flush_in;

    assign op_stall = start | (busy & ~flush_in);

    // TLB port strobes follow the state even under flush: a started write completes.
    assign tlb_s_req   = (state_q == ST_SEARCH);
    assign tlb_r_req   = (state_q == ST_READ);
    assign tlb_r_index = tlb_r_req ? idx_q : '0;
    assign tlb_we      = (state_q == ST_WRITE);
    assign tlb_w_index = tlb_we ? idx_q : '0;

    assign cp0_tlbp_we    = fin_live & (op_q == OP_TLBP);
    assign cp0_tlbp_found = cp0_tlbp_we & tlb_s_found;
    assign cp0_tlbp_index = cp0_tlbp_we ? tlb_s_index : '0;

    assign cp0_tlbr_we   = fin_live & (op_q == OP_TLBR);
    assign refetch_flush = fin_live & ((op_q == OP_TLBR) | (op_q == OP_TLBWI) | (op_q == OP_TLBWR));

    // pc_q holds the raw m1s PC so that a reset value of 0 shows as a target of 4.
    assign refetch_pc = pc_q + 32'd4;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tlb_op_seq.sv
// Bench for tlb_op_seq: table of single ops plus hand sequences for reset,
// back-to-back and PC wrap; expected output words go through a queue.
module tb_tlb_op_seq;

    localparam int W = 55;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m1s_valid = 1'b0, m1s_ex = 1'b0;
    logic        i_tlbp = 1'b0, i_tlbr = 1'b0, i_tlbwi = 1'b0, i_tlbwr = 1'b0;
    logic [31:0] m1s_pc = 32'd0;
    logic        flush_in = 1'b0;
    logic [3:0]  cp0_index = 4'd0, cp0_random = 4'd0;
    logic        tlb_s_found = 1'b0;
    logic [3:0]  tlb_s_index = 4'd0;

    logic        op_stall, tlb_s_req, tlb_r_req, tlb_we;
    logic [3:0]  tlb_r_index, tlb_w_index, cp0_tlbp_index;
    logic        cp0_tlbp_we, cp0_tlbp_found, cp0_tlbr_we, refetch_flush;
    logic [31:0] refetch_pc;
    logic [2:0]  dbg_state;

    tlb_op_seq #(.TLBNUM(16), .IDXW(4)) dut (
        .clk(clk), .reset(reset),
        .m1s_valid(m1s_valid), .m1s_ex(m1s_ex),
        .m1s_inst_tlbp(i_tlbp), .m1s_inst_tlbr(i_tlbr),
        .m1s_inst_tlbwi(i_tlbwi), .m1s_inst_tlbwr(i_tlbwr),
        .m1s_pc(m1s_pc), .flush_in(flush_in),
        .cp0_index(cp0_index), .cp0_random(cp0_random),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .op_stall(op_stall), .tlb_s_req(tlb_s_req),
        .tlb_r_req(tlb_r_req), .tlb_r_index(tlb_r_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .cp0_tlbp_we(cp0_tlbp_we), .cp0_tlbp_found(cp0_tlbp_found),
        .cp0_tlbp_index(cp0_tlbp_index), .cp0_tlbr_we(cp0_tlbr_we),
        .refetch_flush(refetch_flush), .refetch_pc(refetch_pc),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  last_rpc = 32'd4;

    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic stall,
                                        input logic s, input logic r, input logic [3:0] ri,
                                        input logic w, input logic [3:0] wi,
                                        input logic pwe, input logic pf, input logic [3:0] pi,
                                        input logic rwe, input logic rf, input logic [31:0] rpc);
        return {st, stall, s, r, ri, w, wi, pwe, pf, pi, rwe, rf, rpc};
    endfunction

    function automatic logic [W-1:0] idle_w(input logic [31:0] rpc);
        return mk(S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, rpc);
    endfunction

    task automatic push(input logic [W-1:0] w, input string nm);
        exp_q.push_back(w);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {dbg_state, op_stall, tlb_s_req, tlb_r_req, tlb_r_index, tlb_we, tlb_w_index,
                  cp0_tlbp_we, cp0_tlbp_found, cp0_tlbp_index, cp0_tlbr_we, refetch_flush, refetch_pc};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (st,stall,s,r,ri,w,wi,pwe,pf,pi,rwe,rf,rpc)", nm, a, e);
            end
        end
    end

    // driver
    task automatic drive(input logic v, input logic ex, input logic [3:0] op,
                         input logic [31:0] pc, input logic [3:0] ci, input logic [3:0] cr,
                         input logic fl);
        m1s_valid  = v;
        m1s_ex     = ex;
        {i_tlbp, i_tlbr, i_tlbwi, i_tlbwr} = op;
        m1s_pc     = pc;
        cp0_index  = ci;
        cp0_random = cr;
        flush_in   = fl;
    endtask

    task automatic junk_resp();
        tlb_s_found = 1'($urandom_range(0, 1));
        tlb_s_index = 4'($urandom_range(0, 15));
    endtask

    typedef struct {
        logic [3:0]  op;        // {tlbp, tlbr, tlbwi, tlbwr}
        logic        valid;
        logic        ex;
        int          flush_cyc; // -1 none, else offset from T
        logic [31:0] pc;
        logic [3:0]  cidx;
        logic [3:0]  crand;
        logic        sfound;
        logic [3:0]  sidx;
        logic        e_start;
        logic [2:0]  e_st;
        logic [3:0]  e_idx;
        logic        e_pwe;
        logic        e_found;
        logic [3:0]  e_tidx;
        logic        e_rwe;
        logic        e_rf;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl[NV];

    task automatic run_vec(input vec_t v, input int n);
        logic [31:0] rpc_new;
        logic        f2;
        rpc_new = v.pc + 32'd4;
        f2      = (v.flush_cyc == 2);
        // T
        @(posedge clk); #1;
        drive(v.valid, v.ex, v.op, v.pc, v.cidx, v.crand, v.flush_cyc == 0);
        junk_resp();
        if (v.e_start) begin
            push(mk(S_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, last_rpc),
                 $sformatf("v%0d_T", n));
        end else begin
            push(idle_w(last_rpc), $sformatf("v%0d_T_blocked", n));
        end
        // T+1: Random moves on; a flushed instruction leaves m1s
        @(posedge clk); #1;
        cp0_random = v.crand + 4'd1;
        flush_in   = (v.flush_cyc == 1);
        if (v.flush_cyc == 0) m1s_valid = 1'b0;
        junk_resp();
        if (v.e_start) begin
            push(mk(v.e_st, v.flush_cyc != 1,
                    v.e_st == S_SEARCH,
                    v.e_st == S_READ, (v.e_st == S_READ) ? v.e_idx : 4'd0,
                    v.e_st == S_WRITE, (v.e_st == S_WRITE) ? v.e_idx : 4'd0,
                    1'b0, 1'b0, 4'd0, 1'b0, 1'b0, rpc_new), $sformatf("v%0d_T1", n));
        end else begin
            push(idle_w(last_rpc), $sformatf("v%0d_T1_blocked", n));
        end
        // T+2: registered TLB search response arrives
        @(posedge clk); #1;
        flush_in = f2;
        if (v.flush_cyc == 0 || v.flush_cyc == 1) m1s_valid = 1'b0;
        tlb_s_found = v.sfound;
        tlb_s_index = v.sidx;
        if (v.e_start && v.flush_cyc != 1) begin
            logic pwe;
            pwe = v.e_pwe & ~f2;
            push(mk(S_FINISH, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,
                    pwe, pwe & v.e_found, pwe ? v.e_tidx : 4'd0,
                    v.e_rwe & ~f2, v.e_rf & ~f2, rpc_new), $sformatf("v%0d_T2", n));
        end else if (v.e_start) begin
            push(idle_w(rpc_new), $sformatf("v%0d_T2_flushed", n));
        end else begin
            push(idle_w(last_rpc), $sformatf("v%0d_T2_blocked", n));
        end
        if (v.e_start) last_rpc = rpc_new;
        // T+3
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b0000, 32'd0, 4'd0, 4'd0, 1'b0);
        junk_resp();
        push(idle_w(last_rpc), $sformatf("v%0d_T3", n));
    endtask

    initial begin
        //            op      v  ex fl  pc            ci  cr  sf sidx st e_st      idx pwe fnd tidx rwe rf
        tbl[0]  = '{4'b1000, 1, 0, -1, 32'h80001000, 1,  7,  1, 5,  1, S_SEARCH, 0,  1,  1,  5,   0,  0};
        tbl[1]  = '{4'b1000, 1, 0, -1, 32'h80001010, 1,  7,  0, 0,  1, S_SEARCH, 0,  1,  0,  0,   0,  0};
        tbl[2]  = '{4'b0100, 1, 0, -1, 32'hBFC00100, 3,  8,  0, 0,  1, S_READ,   3,  0,  0,  0,   1,  1};
        tbl[3]  = '{4'b0001, 1, 0, -1, 32'h00400020, 2,  9,  0, 0,  1, S_WRITE,  9,  0,  0,  0,   0,  1};
        tbl[4]  = '{4'b0010, 1, 0, -1, 32'h00400030, 12, 1,  0, 0,  1, S_WRITE,  12, 0,  0,  0,   0,  1};
        tbl[5]  = '{4'b1010, 1, 0, -1, 32'h00400040, 4,  1,  1, 2,  1, S_SEARCH, 0,  1,  1,  2,   0,  0};
        tbl[6]  = '{4'b0101, 1, 0, -1, 32'h00400044, 6,  11, 0, 0,  1, S_READ,   6,  0,  0,  0,   1,  1};
        tbl[7]  = '{4'b0010, 1, 1, -1, 32'h00400048, 5,  1,  0, 0,  0, S_IDLE,   0,  0,  0,  0,   0,  0};
        tbl[8]  = '{4'b0100, 0, 0, -1, 32'h0040004C, 5,  1,  0, 0,  0, S_IDLE,   0,  0,  0,  0,   0,  0};
        tbl[9]  = '{4'b0010, 1, 0, 0,  32'h00400050, 5,  1,  0, 0,  0, S_IDLE,   0,  0,  0,  0,   0,  0};
        tbl[10] = '{4'b0010, 1, 0, 1,  32'h00400054, 7,  1,  0, 0,  1, S_WRITE,  7,  0,  0,  0,   0,  1};
        tbl[11] = '{4'b0100, 1, 0, 2,  32'h00400058, 3,  1,  0, 0,  1, S_READ,   3,  0,  0,  0,   1,  1};
        tbl[12] = '{4'b1000, 1, 0, 2,  32'h0040005C, 3,  1,  1, 9,  1, S_SEARCH, 0,  1,  1,  9,   0,  0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push(idle_w(32'd4), "reset_state");

        for (int i = 0; i < NV; i++) begin
            run_vec(tbl[i], i);
        end

        // tlbwi held in m1s twice: second start at T+3, PC 0xFFFFFFFC wraps to 0
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'b0010, 32'hFFFFFFFC, 4'd4, 4'd0, 1'b0);
        push(mk(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, last_rpc), "b2b_T");
        @(posedge clk); #1;
        push(mk(S_WRITE, 1, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0, 0, 32'h0), "b2b_T1");
        @(posedge clk); #1;
        push(mk(S_FINISH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0), "b2b_T2_wrap");
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'b0010, 32'h00000100, 4'd5, 4'd0, 1'b0);
        push(mk(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), "b2b_T3_start");
        @(posedge clk); #1;
        push(mk(S_WRITE, 1, 0, 0, 0, 1, 4'd5, 0, 0, 0, 0, 0, 32'h104), "b2b_T4");
        @(posedge clk); #1;
        push(mk(S_FINISH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104), "b2b_T5");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b0000, 32'd0, 4'd0, 4'd0, 1'b0);
        push(idle_w(32'h104), "b2b_T6");

        // reset in T+1 of a tlbr: everything quiet at T+2
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'b0100, 32'h00000040, 4'd2, 4'd0, 1'b0);
        push(mk(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104), "rst_T");
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 32'd0, 4'd0, 4'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        push(idle_w(32'd4), "rst_T2");
        @(posedge clk); #1;
        push(idle_w(32'd4), "rst_T3");

        @(posedge clk); #1;
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
